uart_byte_rx: RTL and testbench

8N1 serial receiver for the RS232 link; the receive-side counterpart of the existing byte transmitter. It synchronizes and glitch-filters `rs232_rx` and detects the start edge. It requests bit-centre strobes from the shared baud-rate generator through the `bps_start`/`clk_bps` handshake, then assembles the byte LSB first. A completed byte is reported with a falling edge on `rx_int`, which the transmitter consumes directly for loop-back echo.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_byte_rx.sv | 109 ++++++++++
 tb/tb_uart_byte_rx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | uart_pkg : shared UART types, line levels and baud constants              |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic STOP_LVL = 1'b1;
  localparam logic IDLE_LVL = 1'b1;

  // clk cycles per bit (and per half bit) at 9600 baud from 50 MHz
  localparam int BPS_9600      = 5208;
  localparam int BPS_9600_HALF = 2604;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | uart_rx_sync : 4-stage line synchronizer with glitch-filtered start edge  |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rs232_rx,
  output logic rx_s,
  output logic neg_rx
);

  // sync_q[0] is rx0 (newest sample), sync_q[3] is rx3 (oldest)
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {4{IDLE_LVL}};
    end else begin
      sync_q <= {sync_q[2:0], rs232_rx};
    end
  end

  assign rx_s   = sync_q[1];
  assign neg_rx = sync_q[3] & sync_q[2] & ~sync_q[1] & ~sync_q[0];

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | uart_byte_rx : 8N1 receiver driven by bit-centre strobes from baud gen    |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module uart_byte_rx #(
  parameter int DATA_W = uart_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rs232_rx,
  input  logic              clk_bps,
  output logic              bps_start,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_int,
  output logic              frame_err
);

  import uart_pkg::*;

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic rx_s;
  logic neg_rx;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs232_rx (rs232_rx),
    .rx_s     (rx_s),
    .neg_rx   (neg_rx)
  );

  rx_state_e         state_q;
  logic              bps_start_q;
  logic              rx_int_q;
  logic              frame_err_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bps_start_q <= 1'b0;
      rx_int_q    <= 1'b0;
      frame_err_q <= 1'b0;
      rx_data_q   <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (neg_rx) begin
            bps_start_q <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          if (clk_bps) begin
            if (!rx_s) begin
              rx_int_q <= 1'b1;
              cnt_q    <= '0;
              state_q  <= DATA;
            end else begin
              bps_start_q <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        DATA: begin
          if (clk_bps) begin
            // LSB arrives first, so shift in from the top
            shift_q <= {rx_s, shift_q[DATA_W-1:1]};
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              state_q <= STOP;
            end
          end
        end
        STOP: begin
          if (clk_bps) begin
            if (rx_s == STOP_LVL) begin
              rx_data_q   <= shift_q;
              frame_err_q <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
            end
            rx_int_q    <= 1'b0;
            bps_start_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bps_start = bps_start_q;
  assign rx_int    = rx_int_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;

endmodule : uart_byte_rx
`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_uart_byte_rx : randomized frames checked against a frame-level model   |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_uart_byte_rx;
  import uart_pkg::*;

  // baud rate scaled down 32x to keep the run short; ratios are preserved
  localparam int BIT_P  = BPS_9600 / 32;
  localparam int HALF_P = BPS_9600_HALF / 32;
  localparam int NSTROBE = DATA_W + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rs232_rx;
  logic       clk_bps = 1'b0;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_int;
  logic       frame_err;

  always #5 clk = ~clk;

  uart_byte_rx #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs232_rx  (rs232_rx),
    .clk_bps   (clk_bps),
    .bps_start (bps_start),
    .rx_data   (rx_data),
    .rx_int    (rx_int),
    .frame_err (frame_err)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] m_data = 8'h00;
  logic       m_err  = 1'b0;
  int         pass_cnt = 0;
  int         chk_cnt  = 0;
  int         cyc = 0;
  int         bcnt = 0;
  int         strobe_idx = 0;
  int         prev_idx = -1;
  logic       prev_int = 1'b0;
  bit         idle_strobe_en = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Frame-level model and compare, followed by the baud-generator model
  always @(negedge clk) begin
    frame_t f;
    cyc++;
    if (!rst_n) begin
      prev_int   = 1'b0;
      bcnt       = 0;
      strobe_idx = 0;
      prev_idx   = -1;
      clk_bps    = 1'b0;
    end else begin
      if (rx_int && !prev_int) begin
        check("rise_expected", exp_q.size() > 0, 1);
        check("rise_after_start_strobe", prev_idx, 1);
        check("bps_start_at_rise", bps_start, 1);
      end
      if (!rx_int && prev_int) begin
        check("fall_after_stop_strobe", prev_idx, NSTROBE);
        check("bps_start_cleared_at_fall", bps_start, 0);
        if (exp_q.size() > 0) begin
          f = exp_q.pop_front();
          if (!f.err) m_data = f.data;
          m_err = f.err;
        end else begin
          check("fall_expected", 0, 1);
        end
      end
      check("rx_data", rx_data, m_data);
      check("frame_err", frame_err, m_err);
      prev_int = rx_int;

      if (bps_start) begin
        bcnt++;
        if (bcnt == HALF_P || (bcnt > HALF_P && (bcnt - HALF_P) % BIT_P == 0)) begin
          strobe_idx++;
          clk_bps = 1'b1;
        end else begin
          clk_bps = 1'b0;
        end
      end else begin
        bcnt       = 0;
        strobe_idx = 0;
        clk_bps    = idle_strobe_en && (cyc % 37 == 0);
      end
      prev_idx = clk_bps ? strobe_idx : -1;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_q.push_back('{data: d, err: !stop});
    rs232_rx = 1'b0;
    repeat (BIT_P) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = d[i];
      repeat (BIT_P) @(negedge clk);
    end
    rs232_rx = stop;
    repeat (BIT_P) @(negedge clk);
    rs232_rx = 1'b1;
  endtask

  initial begin
    logic       seen;
    logic [7:0] rd;
    logic       rs;
    int         gap;

    rst_n    = 1'b0;
    rs232_rx = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_bps_start", bps_start, 0);
    check("reset_rx_int", rx_int, 0);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_frame_err", frame_err, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    idle_strobe_en = 1'b1;
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      seen = seen | bps_start | rx_int;
    end
    idle_strobe_en = 1'b0;
    check("idle_strobes_no_effect", seen, 0);
    repeat (10) @(negedge clk);

    send_frame(8'h55, 1'b1);
    check("lit_55_data", rx_data, 8'h55);
    check("lit_55_err", frame_err, 0);
    repeat (10) @(negedge clk);

    send_frame(8'h81, 1'b0);
    check("lit_err_holds_data", rx_data, 8'h55);
    check("lit_err_flag", frame_err, 1);
    check("lit_err_rx_int_low", rx_int, 0);
    repeat (10) @(negedge clk);

    send_frame(8'h42, 1'b1);
    check("lit_42_data", rx_data, 8'h42);
    check("lit_42_err", frame_err, 0);
    repeat (10) @(negedge clk);

    send_frame(8'hA3, 1'b1);
    check("lit_A3_data", rx_data, 8'hA3);
    send_frame(8'h0F, 1'b1);
    check("lit_0F_data", rx_data, 8'h0F);
    repeat (20) @(negedge clk);

    rs232_rx = 1'b0;
    @(negedge clk);
    rs232_rx = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | bps_start;
    end
    check("glitch_no_bps_start", seen, 0);

    // long low pulse: false start, detected with two-edge latency
    rs232_rx = 1'b0;
    @(negedge clk);
    check("edge_lat_n", bps_start, 0);
    @(negedge clk);
    check("edge_lat_n1", bps_start, 0);
    @(negedge clk);
    check("edge_lat_n2", bps_start, 1);
    repeat (28) @(negedge clk);
    rs232_rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < HALF_P + 20; i++) begin
      @(negedge clk);
      if (!bps_start) begin
        seen = 1'b1;
        break;
      end
    end
    check("false_start_bps_fall", seen, 1);
    check("false_start_keeps_data", rx_data, 8'h0F);
    repeat (20) @(negedge clk);

    // reset mid-frame, after data bit 3 has been sampled
    exp_q.push_back('{data: 8'hC6, err: 1'b0});
    rs232_rx = 1'b0;
    repeat (BIT_P) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rs232_rx = i[0];
      repeat (BIT_P) @(negedge clk);
    end
    rs232_rx = 1'b1;
    repeat (BIT_P / 2) @(negedge clk);
    check("pre_reset_rx_int", rx_int, 1);
    #3;
    rst_n    = 1'b0;
    rs232_rx = 1'b1;
    exp_q.delete();
    m_data = 8'h00;
    m_err  = 1'b0;
    #1;
    check("async_rst_bps_start", bps_start, 0);
    check("async_rst_rx_int", rx_int, 0);
    check("async_rst_rx_data", rx_data, 8'h00);
    check("async_rst_frame_err", frame_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT_P) @(negedge clk);
    send_frame(8'h3C, 1'b1);
    check("lit_3C_data", rx_data, 8'h3C);
    check("lit_3C_err", frame_err, 0);

    for (int k = 0; k < 14; k++) begin
      rd  = 8'($urandom_range(0, 255));
      rs  = ($urandom_range(0, 3) != 0);
      send_frame(rd, rs);
      gap = rs ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20));
      repeat (gap) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    check("all_frames_reported", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_uart_byte_rx
`default_nettype wire
